// File: rtl/riscv_sig_dump.sv
`timescale 1ns/1ps
// Signature dumper: reads RAM words in [BEGIN,END) over a host port and streams them out.
// Latency: device port responds 1 cycle after a request; >=3 cycles per dumped word.
// Backpressure: holds host_req_o until grant and each word until sig_ready_i; one read in flight.
module riscv_sig_dump #(
  parameter logic [31:0] DefaultBegin = 32'h0,
  parameter logic [31:0] DefaultEnd   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [31:0] dev_wdata_i,
  input  logic [3:0]  dev_be_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        sig_valid_o,
  input  logic        sig_ready_i,
  output logic [31:0] sig_data_o,
  output logic        sig_last_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] begin_q, begin_d, end_q, end_d;
  logic [31:0] cur_q, cur_d, count_q, count_d, buf_q, buf_d;
  logic        done_q, done_d, err_q, err_d;
  logic        dev_rvalid_q;
  logic [31:0] dev_rdata_q, dev_rdata_d;
  logic        dev_err_q, dev_err_d;

  logic [2:0]  reg_sel;
  logic        busy, dev_wr, start, last;
  logic        unused_ok;

  assign reg_sel = dev_addr_i[4:2];
  assign busy    = (state_q != StIdle);
  assign dev_wr  = dev_req_i & dev_we_i;
  assign start   = dev_wr && (reg_sel == 3'd2) && dev_wdata_i[0] && !busy;
  // 33-bit compare so a region ending near the top of memory cannot wrap
  assign last    = ({1'b0, cur_q} + 33'd4) >= {1'b0, end_q};
  assign unused_ok = ^{dev_be_i, dev_addr_i[31:5], dev_addr_i[1:0], dev_wdata_i[1]};

  // Register read mux and decode error for the device response
  always_comb begin
    dev_rdata_d = '0;
    dev_err_d   = 1'b0;
    case (reg_sel)
      3'd0:    dev_rdata_d = begin_q;
      3'd1:    dev_rdata_d = end_q;
      3'd2:    dev_rdata_d = '0;
      3'd3:    dev_rdata_d = {29'd0, err_q, done_q, busy};
      3'd4:    dev_rdata_d = count_q;
      default: dev_err_d   = 1'b1;
    endcase
    if (!dev_req_i || dev_we_i) dev_rdata_d = '0;
    if (!dev_req_i)             dev_err_d   = 1'b0;
  end

  // Register writes and dump sequencing: REQ -> WAIT -> OUT per word
  always_comb begin
    state_d = state_q;
    begin_d = begin_q;
    end_d   = end_q;
    cur_d   = cur_q;
    count_d = count_q;
    buf_d   = buf_q;
    done_d  = done_q;
    err_d   = err_q;
    // bounds are frozen during a dump so sig_last_o stays consistent
    if (dev_wr && !busy) begin
      if (reg_sel == 3'd0) begin_d = {dev_wdata_i[31:2], 2'b00};
      if (reg_sel == 3'd1) end_d   = {dev_wdata_i[31:2], 2'b00};
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          cur_d   = begin_q;
          if (begin_q < end_q) state_d = StReq;
          else                 done_d  = 1'b1;
        end
      end
      StReq: begin
        if (host_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (host_rvalid_i) begin
          buf_d = host_rdata_i;
          if (host_err_i) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StOut;
          end
        end
      end
      default: begin
        if (sig_ready_i) begin
          count_d = count_q + 32'd1;
          cur_d   = cur_q + 32'd4;
          if (last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StReq;
          end
        end
      end
    endcase
  end

  // State and register storage; reset aborts any dump in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      begin_q      <= DefaultBegin;
      end_q        <= DefaultEnd;
      cur_q        <= '0;
      count_q      <= '0;
      buf_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      begin_q      <= begin_d;
      end_q        <= end_d;
      cur_q        <= cur_d;
      count_q      <= count_d;
      buf_q        <= buf_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dev_rvalid_q <= dev_req_i;
      dev_rdata_q  <= dev_rdata_d;
      dev_err_q    <= dev_err_d;
    end
  end

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;
  assign host_req_o   = (state_q == StReq);
  assign host_addr_o  = cur_q;
  assign host_we_o    = 1'b0;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = '0;
  assign sig_valid_o  = (state_q == StOut);
  assign sig_data_o   = buf_q;
  assign sig_last_o   = (state_q == StOut) && last;

endmodule
